// File: rtl/sens_hispi_pkg.sv
// Shared constants and types for the HiSPi lane aligner: preamble pattern,
// sync code values, FSM encoding and the word-pipe entry.
package sens_hispi_pkg;

    localparam logic [35:0] HISPI_PREAMBLE = 36'hFFF000000;

    localparam logic [2:0] SOF = 3'b011;
    localparam logic [2:0] SOL = 3'b001;
    localparam logic [2:0] EOF = 3'b111;
    localparam logic [2:0] EOL = 3'b101;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CODE   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        logic        vld;
        logic [11:0] word;
    } pword_t;

endpackage

// File: rtl/sens_hispi_sync_match.sv
// Looks for the FFF,000,000 preamble at the four possible bit offsets of the
// shift register; the lowest matching offset wins.
module sens_hispi_sync_match
    import sens_hispi_pkg::*;
(
    input  logic [38:0] sreg_i,
    output logic        match_o,
    output logic [1:0]  s_o
);

    always_comb begin
        match_o = 1'b0;
        s_o     = 2'd0;
        // Descending scan so the last (lowest) hit overrides the others.
        for (int s = 3; s >= 0; s--) begin
            if (sreg_i[s +: 36] == HISPI_PREAMBLE) begin
                match_o = 1'b1;
                s_o     = 2'(s);
            end
        end
    end

endmodule

// File: rtl/sens_hispi_lane.sv
// HiSPi lane word aligner: locks 12-bit alignment on the sync preamble,
// decodes the sync code and delivers pixel words with frame/line markers.
module sens_hispi_lane
    import sens_hispi_pkg::*;
#(
    parameter bit HISPI_MSB_FIRST = 1'b1,
    parameter bit HISPI_REALIGN   = 1'b1
) (
    input  logic        ipclk,
    input  logic        irst,
    input  logic [3:0]  din,
    output logic [11:0] dout,
    output logic        dv,
    output logic        sof,
    output logic        sol,
    output logic        eof,
    output logic        eol,
    output logic        in_line,
    output logic        locked,
    output logic [1:0]  shift,
    output logic        realign,
    output logic        bad_code
);

    // Only the newest 39 bits can ever reach a match window or sample word.
    localparam int SREG_W = 39;

    state_e              state_q, state_d;
    logic [SREG_W-1:0]   sreg_q, sreg_d;
    logic [1:0]          ph_q, ph_d;
    logic [1:0]          shift_q, shift_d;
    logic                locked_q, locked_d;
    logic                in_line_q, in_line_d;
    logic                from_lk_q, from_lk_d;
    logic                sof_q, sof_d, sol_q, sol_d, eof_q, eof_d, eol_q, eol_d;
    logic                realign_q, realign_d, bad_q, bad_d;
    logic                dv_q, dv_d;
    logic [11:0]         dout_q, dout_d;
    pword_t              p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;

    logic [3:0]  nib;
    logic        m_hit;
    logic [1:0]  m_s;
    logic [11:0] word;
    logic        sample, take, flush, code_ok;
    pword_t      pa, pb, pc;

    assign nib    = HISPI_MSB_FIRST ? din : {din[0], din[1], din[2], din[3]};
    assign sreg_d = {sreg_q[SREG_W-5:0], nib};
    assign word   = sreg_q[shift_q +: 12];
    assign sample = (state_q != HUNT) && (ph_q == 2'd0);

    sens_hispi_sync_match u_match (
        .sreg_i  (sreg_q),
        .match_o (m_hit),
        .s_o     (m_s)
    );

    always_comb begin
        take      = 1'b0;
        flush     = 1'b0;
        code_ok   = 1'b0;
        state_d   = state_q;
        ph_d      = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
        shift_d   = shift_q;
        locked_d  = locked_q;
        in_line_d = in_line_q;
        from_lk_d = from_lk_q;
        sof_d     = 1'b0;
        sol_d     = 1'b0;
        eof_d     = 1'b0;
        eol_d     = 1'b0;
        bad_d     = 1'b0;
        realign_d = 1'b0;
        dv_d      = 1'b0;
        dout_d    = dout_q;
        pa        = p0_q;
        pb        = p1_q;
        pc        = p2_q;

        case (state_q)
            LOCKED: begin
                if (m_hit) begin
                    if (m_s == shift_q && sample) begin
                        take = 1'b1;
                    end else if (HISPI_REALIGN) begin
                        take  = 1'b1;
                        flush = 1'b1;
                    end
                end
            end
            default: take = m_hit;
        endcase

        if (take) begin
            state_d = CODE;
            shift_d = m_s;
            ph_d    = 2'd1;
            if (state_q != CODE) from_lk_d = (state_q == LOCKED);
            // The two older preamble words are still in the pipe; drop them.
            pa.vld = 1'b0;
            pb.vld = 1'b0;
            if (flush) begin
                pc.vld    = 1'b0;
                realign_d = 1'b1;
                in_line_d = 1'b0;
            end
        end else if (sample && state_q == CODE) begin
            code_ok = 1'b1;
            case (word[2:0])
                SOF:     begin sof_d = 1'b1; in_line_d = 1'b1; end
                SOL:     begin sol_d = 1'b1; in_line_d = 1'b1; end
                EOF:     begin eof_d = 1'b1; in_line_d = 1'b0; end
                EOL:     begin eol_d = 1'b1; in_line_d = 1'b0; end
                default: code_ok = 1'b0;
            endcase
            if (code_ok) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
            end else begin
                bad_d = 1'b1;
                if (from_lk_q) begin
                    state_d = LOCKED;
                end else begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            end
        end

        if (sample) begin
            dout_d = pc.word;
            dv_d   = pc.vld;
            p2_d   = pb;
            p1_d   = pa;
            p0_d   = '{vld: (state_q == LOCKED) && in_line_q && !take, word: word};
        end else begin
            p2_d = pc;
            p1_d = pb;
            p0_d = pa;
        end
    end

    always_ff @(posedge ipclk) begin
        if (irst) begin
            state_q   <= HUNT;
            sreg_q    <= '0;
            ph_q      <= '0;
            shift_q   <= '0;
            locked_q  <= 1'b0;
            in_line_q <= 1'b0;
            from_lk_q <= 1'b0;
            sof_q     <= 1'b0;
            sol_q     <= 1'b0;
            eof_q     <= 1'b0;
            eol_q     <= 1'b0;
            bad_q     <= 1'b0;
            realign_q <= 1'b0;
            dv_q      <= 1'b0;
            dout_q    <= '0;
            p0_q      <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            ph_q      <= ph_d;
            shift_q   <= shift_d;
            locked_q  <= locked_d;
            in_line_q <= in_line_d;
            from_lk_q <= from_lk_d;
            sof_q     <= sof_d;
            sol_q     <= sol_d;
            eof_q     <= eof_d;
            eol_q     <= eol_d;
            bad_q     <= bad_d;
            realign_q <= realign_d;
            dv_q      <= dv_d;
            dout_q    <= dout_d;
            p0_q      <= p0_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
        end
    end

    assign dout     = dout_q;
    assign dv       = dv_q;
    assign sof      = sof_q;
    assign sol      = sol_q;
    assign eof      = eof_q;
    assign eol      = eol_q;
    assign in_line  = in_line_q;
    assign locked   = locked_q;
    assign shift    = shift_q;
    assign realign  = realign_q;
    assign bad_code = bad_q;

endmodule
